// File: rtl/gate_tt_pkg.sv
// gate_tt_pkg
// Shared definitions for the gate truth-table checker:
//   state_e   - checker FSM states (also exported on the debug state port)
//   tt_width  - number of minterms (truth-table rows) for n gate inputs
package gate_tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/gate_tt_checker_if.sv
// gate_tt_checker_if
// Bundles the checker's control handshake, result outputs and the gate-side
// stimulus/response signals.
//   start/busy      : request handshake. A start is taken only when the
//                     checker is idle (busy=0) and start=1 at a rising edge;
//                     busy then stays high until the done cycle inclusive.
//                     start while busy=1 is dropped, never queued.
//   done/pass/...   : done pulses one cycle at sweep end; pass, mismatch_cnt,
//                     first_fail, tt_out hold until the next accepted start.
//   dut_in          : vector driven to both gate implementations.
//   resp_a/resp_b   : structural / expression gate responses.
// Modports: master = checker side, slave = environment (requester + gates).
interface gate_tt_checker_if
    import gate_tt_pkg::*;
#(
    parameter int N_IN = 2
) ();

    logic                      start;
    logic                      busy;
    logic                      done;
    logic                      pass;
    logic [N_IN:0]             mismatch_cnt;
    logic [N_IN-1:0]           first_fail;
    logic [tt_width(N_IN)-1:0] tt_out;
    logic [N_IN-1:0]           dut_in;
    logic                      resp_a;
    logic                      resp_b;

    modport master (
        input  start, resp_a, resp_b,
        output busy, done, pass, mismatch_cnt, first_fail, tt_out, dut_in
    );

    modport slave (
        output start, resp_a, resp_b,
        input  busy, done, pass, mismatch_cnt, first_fail, tt_out, dut_in
    );

endinterface

// File: rtl/tt_vec_counter.sv
// tt_vec_counter
// Vector counter and settle timer for the truth-table sweep.
//   clk, rst     : clock, synchronous active-high reset
//   vec_clr      : reset the vector to minterm 0
//   vec_inc      : advance to the next minterm (no wrap is ever requested)
//   settle_load  : reload the settle timer with SETTLE
//   settle_dec   : count the settle timer down by one
//   vec          : current minterm
//   last         : vec is the final minterm (all ones)
//   expired      : the current DRIVE cycle is the last one of the hold time
module tt_vec_counter #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vec_clr,
    input  logic            vec_inc,
    input  logic            settle_load,
    input  logic            settle_dec,
    output logic [N_IN-1:0] vec,
    output logic            last,
    output logic            expired
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);

    logic [N_IN-1:0] vec_q, vec_d;
    logic [SW-1:0]   settle_q, settle_d;

    always_comb begin
        vec_d    = vec_q;
        settle_d = settle_q;
        if (vec_clr) begin
            vec_d = '0;
        end else if (vec_inc) begin
            vec_d = vec_q + N_IN'(1);
        end
        if (settle_load) begin
            settle_d = SETTLE_LD;
        end else if (settle_dec && (settle_q != '0)) begin
            settle_d = settle_q - SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q    <= '0;
            settle_q <= '0;
        end else begin
            vec_q    <= vec_d;
            settle_q <= settle_d;
        end
    end

    assign vec     = vec_q;
    assign last    = (vec_q == {N_IN{1'b1}});
    // The timer is loaded with SETTLE as DRIVE begins, so the DRIVE cycle
    // that sees 1 is the SETTLE-th one.
    assign expired = (settle_q <= SW'(1));

endmodule

// File: rtl/gate_tt_checker.sv
// gate_tt_checker
// Sweeps every minterm of an N_IN-input gate, holds each vector SETTLE
// cycles, samples the structural (resp_a) and expression (resp_b) responses,
// and reports the captured truth table, mismatch count, first failing
// minterm and an overall pass flag.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : checker side of gate_tt_checker_if (handshake, results, gate I/O)
//   dbg_state : current FSM state
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    gate_tt_checker_if.master  bus,
    output state_e             dbg_state
);

    localparam int TT_W = tt_width(N_IN);

    state_e            state_q, state_d;
    logic [N_IN:0]     mm_q, mm_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic              pass_q, pass_d;

    logic              vec_clr, vec_inc, settle_load, settle_dec;
    logic [N_IN-1:0]   vec;
    logic              last, expired;

    tt_vec_counter #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .vec_clr     (vec_clr),
        .vec_inc     (vec_inc),
        .settle_load (settle_load),
        .settle_dec  (settle_dec),
        .vec         (vec),
        .last        (last),
        .expired     (expired)
    );

    always_comb begin
        state_d     = state_q;
        vec_clr     = 1'b0;
        vec_inc     = 1'b0;
        settle_load = 1'b0;
        settle_dec  = 1'b0;
        mm_d        = mm_q;
        ff_d        = ff_q;
        tt_d        = tt_q;
        pass_d      = pass_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_DRIVE;
                    vec_clr     = 1'b1;
                    settle_load = 1'b1;
                    mm_d        = '0;
                    ff_d        = '0;
                    tt_d        = '0;
                    pass_d      = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (expired) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                tt_d[vec] = bus.resp_a;
                if (bus.resp_a != bus.resp_b) begin
                    mm_d = mm_q + (N_IN+1)'(1);
                    if (mm_q == '0) begin
                        ff_d = vec;
                    end
                end
                // Last-vector test comes before any increment, so the
                // vector never wraps and keeps its final value afterwards.
                if (last) begin
                    state_d = ST_DONE;
                    // Settled on entry to DONE so pass is valid with done.
                    pass_d  = (mm_d == '0);
                end else begin
                    state_d     = ST_DRIVE;
                    vec_inc     = 1'b1;
                    settle_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mm_q    <= '0;
            ff_q    <= '0;
            tt_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mm_q    <= mm_d;
            ff_q    <= ff_d;
            tt_q    <= tt_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.dut_in       = vec;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.done         = (state_q == ST_DONE);
    assign bus.pass         = pass_q;
    assign bus.mismatch_cnt = mm_q;
    assign bus.first_fail   = ff_q;
    assign bus.tt_out       = tt_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// tb_gate_tt_checker
// Drives two checker instances: a 2-input one wired to structural and
// expression forms of a'.b (resp_b selectable: correct, tied 0, inverted),
// and a 3-input SETTLE=3 one wired to AND3 on both sides.
module tb_gate_tt_checker;
  import gate_tt_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // ---------------- DUT 1: N_IN=2, SETTLE=1, gate a'.b ----------------
  gate_tt_checker_if #(.N_IN(2)) bus1 ();
  state_e dbg1;
  int     mode;   // 0: resp_b correct, 1: resp_b tied 0, 2: resp_b = ~resp_a

  gate_tt_checker #(.N_IN(2), .SETTLE(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus1),
    .dbg_state (dbg1)
  );

  logic na, g_struct, g_expr;
  not u_not (na, bus1.dut_in[1]);
  and u_and (g_struct, na, bus1.dut_in[0]);
  assign g_expr      = ~bus1.dut_in[1] & bus1.dut_in[0];
  assign bus1.resp_a = g_struct;
  assign bus1.resp_b = (mode == 0) ? g_expr : (mode == 1) ? 1'b0 : ~g_struct;

  // ---------------- DUT 2: N_IN=3, SETTLE=3, AND3 ----------------
  gate_tt_checker_if #(.N_IN(3)) bus2 ();
  state_e dbg2;

  gate_tt_checker #(.N_IN(3), .SETTLE(3)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2),
    .dbg_state (dbg2)
  );

  assign bus2.resp_a = &bus2.dut_in;
  assign bus2.resp_b = bus2.dut_in[2] & bus2.dut_in[1] & bus2.dut_in[0];

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on DUT 1 and run to done. lat counts cycles after the
  // acceptance edge (first DRIVE cycle = 1); busy_cyc counts busy cycles.
  task automatic run1(input int mode_i, output int lat, output int busy_cyc);
    mode = mode_i;
    tick();
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    lat = 1;
    busy_cyc = 0;
    while (!bus1.done && lat < 40) begin
      if (bus1.busy) busy_cyc++;
      tick();
      lat++;
    end
    if (bus1.busy) busy_cyc++;
  endtask

  // Results seen in the done cycle, then one cycle later (busy low, held).
  task automatic check_run1(input string tag, input int lat, input int busy_cyc,
                            input int exp_mm, input int exp_ff, input int exp_pass);
    chk({tag, "_done_lat"}, lat, 9);
    chk({tag, "_busy_cycles"}, busy_cyc, 9);
    chk({tag, "_tt"}, 32'(bus1.tt_out), 32'h2);
    chk({tag, "_mm"}, 32'(bus1.mismatch_cnt), exp_mm);
    chk({tag, "_ff"}, 32'(bus1.first_fail), exp_ff);
    chk({tag, "_pass"}, 32'(bus1.pass), exp_pass);
    chk({tag, "_dut_in_final"}, 32'(bus1.dut_in), 32'h3);
    tick();
    chk({tag, "_busy_after"}, 32'(bus1.busy), 0);
    chk({tag, "_done_after"}, 32'(bus1.done), 0);
    chk({tag, "_mm_hold"}, 32'(bus1.mismatch_cnt), exp_mm);
    chk({tag, "_pass_hold"}, 32'(bus1.pass), exp_pass);
    chk({tag, "_dut_in_hold"}, 32'(bus1.dut_in), 32'h3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, busy_cyc, n_done, d0, d1, d2, prev, run, seen;

    rst = 1'b1;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk("rst_state", 32'(dbg1), 32'(ST_IDLE));
    chk("rst_dut_in", 32'(bus1.dut_in), 0);
    chk("rst_busy", 32'(bus1.busy), 0);
    chk("rst_done", 32'(bus1.done), 0);
    chk("rst_pass", 32'(bus1.pass), 0);
    chk("rst_mm", 32'(bus1.mismatch_cnt), 0);
    chk("rst_ff", 32'(bus1.first_fail), 0);
    chk("rst_tt", 32'(bus1.tt_out), 0);
    chk("rst_tt2", 32'(bus2.tt_out), 0);

    // correct gates on both sides
    run1(0, lat, busy_cyc);
    check_run1("ok", lat, busy_cyc, 0, 0, 1);

    // resp_b tied 0: only minterm 1 (a=0,b=1) differs
    run1(1, lat, busy_cyc);
    check_run1("tie0", lat, busy_cyc, 1, 1, 0);

    // resp_b inverted: every minterm differs
    run1(2, lat, busy_cyc);
    check_run1("inv", lat, busy_cyc, 4, 0, 0);

    // reset asserted during cycle k+4 aborts the sweep
    mode = 0;
    tick();
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    repeat (3) tick();            // now in cycle k+4
    rst = 1'b1;
    tick();                       // cycle k+5
    rst = 1'b0;
    chk("abort_state", 32'(dbg1), 32'(ST_IDLE));
    chk("abort_busy", 32'(bus1.busy), 0);
    chk("abort_dut_in", 32'(bus1.dut_in), 0);
    chk("abort_tt", 32'(bus1.tt_out), 0);
    chk("abort_mm", 32'(bus1.mismatch_cnt), 0);
    chk("abort_pass", 32'(bus1.pass), 0);
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus1.done) n_done++;
      tick();
    end
    chk("abort_no_done", n_done, 0);
    run1(0, lat, busy_cyc);
    check_run1("after_abort", lat, busy_cyc, 0, 0, 1);

    // extra start pulses at k+3 and k+9 are dropped
    tick();
    bus1.start = 1'b1;
    tick();
    n_done = 0;
    d0 = 0;
    for (int c = 1; c <= 20; c++) begin
      bus1.start = (c == 3 || c == 9);
      if (bus1.done) begin
        n_done++;
        d0 = c;
      end
      tick();
    end
    bus1.start = 1'b0;
    chk("extra_start_dones", n_done, 1);
    chk("extra_start_done_lat", d0, 9);
    chk("extra_start_idle", 32'(bus1.busy), 0);

    // start held high: DONE, one IDLE cycle, then the next 8-cycle run
    bus1.start = 1'b1;
    n_done = 0;
    d0 = 0; d1 = 0; d2 = 0;
    for (int c = 0; c < 36; c++) begin
      if (bus1.done) begin
        if (n_done == 0) d0 = c;
        else if (n_done == 1) d1 = c;
        else if (n_done == 2) d2 = c;
        n_done++;
      end
      tick();
    end
    bus1.start = 1'b0;
    chk("held_done_count", n_done, 3);
    chk("held_spacing_1", d1 - d0, 10);
    chk("held_spacing_2", d2 - d1, 10);
    repeat (15) tick();
    chk("held_idle", 32'(bus1.busy), 0);

    // N_IN=3, SETTLE=3, AND3
    tick();
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    lat = 1;
    prev = int'(bus2.dut_in);
    chk("n3_first_vec", prev, 0);
    chk("n3_busy", 32'(bus2.busy), 1);
    run = 1;
    seen = 1;
    while (!bus2.done && lat < 80) begin
      tick();
      lat++;
      if (!bus2.done) begin
        if (int'(bus2.dut_in) == prev) begin
          run++;
        end else begin
          chk("n3_hold_len", run, 4);
          chk("n3_vec_step", 32'(bus2.dut_in), prev + 1);
          prev = int'(bus2.dut_in);
          run = 1;
          seen++;
        end
      end
    end
    chk("n3_last_hold_len", run, 4);
    chk("n3_vectors", seen, 8);
    chk("n3_done_lat", lat, 33);
    chk("n3_tt", 32'(bus2.tt_out), 32'h80);
    chk("n3_mm", 32'(bus2.mismatch_cnt), 0);
    chk("n3_ff", 32'(bus2.first_fail), 0);
    chk("n3_pass", 32'(bus2.pass), 1);
    chk("n3_dut_in_final", 32'(bus2.dut_in), 7);
    tick();
    chk("n3_busy_after", 32'(bus2.busy), 0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
